// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and types for the display and
// address-generation blocks.
package vga_pkg;

  localparam int unsigned H_DISP_DEF   = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_DISP_DEF   = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned TICK_DIV_DEF = 2;

  localparam int unsigned H_TOTAL = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Counters and all comparisons are 10 bits wide; totals above 1023 are illegal.
  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } sync_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: one clk-wide p_tick every TICK_DIV cycles, first one
// TICK_DIV-1 cycles after reset releases; TICK_DIV=1 holds it high.
module pixel_tick_gen #(
  parameter int unsigned TICK_DIV = 2
)(
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_nxt;

  always_comb div_nxt = (div_q == LAST) ? '0 : div_q + DW'(1);

  // p_tick is registered off the next count so it lines up with div_q == LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      p_tick <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      p_tick <= (div_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered sync, visible and
// line/frame start pulses, all aligned to the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP   = H_DISP_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_DISP   = V_DISP_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
)(
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam cnt_t H_LAST = cnt_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_DISP);
  localparam cnt_t V_VIS  = cnt_t'(V_DISP);
  localparam cnt_t HS_BEG = cnt_t'(H_DISP + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_DISP + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_DISP + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_DISP + V_FP + V_SYNC);

  function automatic sync_t decode(input cnt_t x, input cnt_t y);
    sync_t s;
    s.hsync   = !((x >= HS_BEG) && (x < HS_END));
    s.vsync   = !((y >= VS_BEG) && (y < VS_END));
    s.visible = (x < H_VIS) && (y < V_VIS);
    return s;
  endfunction

  logic  x_wrap, y_wrap;
  cnt_t  x_nxt, y_nxt;
  sync_t sync_q, sync_nxt;

  pixel_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    x_wrap   = (pixel_x == H_LAST);
    y_wrap   = (pixel_y == V_LAST);
    x_nxt    = x_wrap ? '0 : pixel_x + cnt_t'(1);
    y_nxt    = !x_wrap ? pixel_y : (y_wrap ? '0 : pixel_y + cnt_t'(1));
    sync_nxt = decode(x_nxt, y_nxt);
  end

  // Sync/visible are decoded from the next position so they change on the
  // same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      sync_q      <= '{hsync: 1'b1, vsync: 1'b1, visible: 1'b1};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= p_tick && x_wrap;
      frame_start <= p_tick && x_wrap && y_wrap;
      if (p_tick) begin
        pixel_x <= x_nxt;
        pixel_y <= y_nxt;
        sync_q  <= sync_nxt;
      end
    end
  end

  assign hsync   = sync_q.hsync;
  assign vsync   = sync_q.vsync;
  assign visible = sync_q.visible;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small-geometry instances for full-frame and reset checks,
// default-geometry instance for the 640-wide line timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s = 1'b1, rst_d = 1'b1, rst_o = 1'b1;

  // Small geometry: H_TOTAL 32 (hsync x 20..25), V_TOTAL 20 (vsync y 14..15)
  logic       s_hs, s_vs, s_vis, s_pt, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       d_hs, d_vs, d_vis, d_pt, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       o_hs, o_vs, o_vis, o_pt, o_ls, o_fs;
  logic [9:0] o_x, o_y;

  vga_timing_gen #(.H_DISP(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .TICK_DIV(2)) dut_s (
    .clk(clk), .reset(rst_s), .hsync(s_hs), .vsync(s_vs), .visible(s_vis), .p_tick(s_pt),
    .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls), .frame_start(s_fs));

  vga_timing_gen dut_d (
    .clk(clk), .reset(rst_d), .hsync(d_hs), .vsync(d_vs), .visible(d_vis), .p_tick(d_pt),
    .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls), .frame_start(d_fs));

  vga_timing_gen #(.H_DISP(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_DISP(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .TICK_DIV(1)) dut_o (
    .clk(clk), .reset(rst_o), .hsync(o_hs), .vsync(o_vs), .visible(o_vis), .p_tick(o_pt),
    .pixel_x(o_x), .pixel_y(o_y), .line_start(o_ls), .frame_start(o_fs));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pc, ex, ey;
    int e_x, e_y, e_hs, e_vs, e_vis, e_pt, e_ls, e_fs;
    int n_ls, n_fs, last_fs, fs_per, hs_cyc, hs_first, hs_last;
    int vis639, vis640, ls_y;

    repeat (3) @(negedge clk);
    chk("rst_x", s_x, 0);          chk("rst_y", s_y, 0);
    chk("rst_ptick", s_pt, 0);     chk("rst_hsync", s_hs, 1);
    chk("rst_vsync", s_vs, 1);     chk("rst_visible", s_vis, 1);
    chk("rst_line_start", s_ls, 0); chk("rst_frame_start", s_fs, 0);

    // Small geometry, TICK_DIV=2: position at sample k is pixel count k/2.
    rst_s = 1'b0;
    {e_x, e_y, e_hs, e_vs, e_vis, e_pt, e_ls, e_fs} = '0;
    n_ls = 0; n_fs = 0; last_fs = 0; fs_per = 0; hs_cyc = 0;
    for (int k = 1; k <= 3199; k++) begin
      @(negedge clk);
      pc = k / 2; ex = pc % 32; ey = (pc / 32) % 20;
      if (k == 1) begin chk("first_ptick", s_pt, 1); chk("first_x", s_x, 0); end
      if (k == 2) begin chk("second_ptick", s_pt, 0); chk("x_after_tick", s_x, 1); end
      if (s_x !== 10'(ex)) e_x++;
      if (s_y !== 10'(ey)) e_y++;
      if (s_hs !== !(ex >= 20 && ex < 26)) e_hs++;
      if (s_vs !== !(ey >= 14 && ey < 16)) e_vs++;
      if (s_vis !== (ex < 16 && ey < 12)) e_vis++;
      if (s_pt !== k[0]) e_pt++;
      if (s_ls !== (k % 2 == 0 && pc > 0 && ex == 0)) e_ls++;
      if (s_fs !== (k % 2 == 0 && pc > 0 && pc % 640 == 0)) e_fs++;
      if (s_ls === 1'b1) n_ls++;
      if (s_fs === 1'b1) begin
        if (last_fs > 0) fs_per = k - last_fs;
        last_fs = k;
        n_fs++;
      end
      if (pc < 32 && s_hs === 1'b0) hs_cyc++;
    end
    chk("s_x_track", e_x, 0);       chk("s_y_track", e_y, 0);
    chk("s_hsync_track", e_hs, 0);  chk("s_vsync_track", e_vs, 0);
    chk("s_visible_track", e_vis, 0); chk("s_ptick_track", e_pt, 0);
    chk("s_line_start_track", e_ls, 0); chk("s_frame_start_track", e_fs, 0);
    chk("s_line_count", n_ls, 49);  chk("s_frame_count", n_fs, 2);
    chk("s_frame_period", fs_per, 1280);
    chk("s_hsync_low_cycles", hs_cyc, 12);

    // Reset just as the line would wrap: no pulse may escape.
    chk("pre_rst_x", s_x, 31); chk("pre_rst_y", s_y, 9); chk("pre_rst_ptick", s_pt, 1);
    rst_s = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", s_x, 0);       chk("mid_rst_y", s_y, 0);
    chk("mid_rst_ptick", s_pt, 0);  chk("mid_rst_hsync", s_hs, 1);
    chk("mid_rst_vsync", s_vs, 1);  chk("mid_rst_visible", s_vis, 1);
    chk("mid_rst_line_start", s_ls, 0); chk("mid_rst_frame_start", s_fs, 0);
    rst_s = 1'b0;
    n_ls = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) chk("post_rst_ptick", s_pt, 1);
      if (s_ls === 1'b1 || s_fs === 1'b1) n_ls++;
    end
    chk("post_rst_pulses", n_ls, 0);
    chk("post_rst_x", s_x, 2);

    // Default 640x480 geometry: one full line plus a bit.
    rst_d = 1'b0;
    hs_cyc = 0; hs_first = -1; hs_last = -1; n_ls = 0; ls_y = -1; vis639 = -1; vis640 = -1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (d_hs === 1'b0) begin
        hs_cyc++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (d_ls === 1'b1) begin n_ls++; ls_y = int'(d_y) * 1000 + int'(d_x); end
      if (d_x == 10'd639 && d_y == 10'd0) vis639 = int'(d_vis);
      if (d_x == 10'd640 && d_y == 10'd0) vis640 = int'(d_vis);
    end
    chk("d_hsync_low_cycles", hs_cyc, 192);
    chk("d_hsync_first_x", hs_first, 656);
    chk("d_hsync_last_x", hs_last, 751);
    chk("d_line_start_count", n_ls, 1);
    chk("d_line_start_pos", ls_y, 1000);
    chk("d_visible_639", vis639, 1);
    chk("d_visible_640", vis640, 0);
    chk("d_y_end", d_y, 1);
    chk("d_vsync_line1", d_vs, 1);

    // TICK_DIV=1: p_tick solid high after reset, one pixel per clk.
    rst_o = 1'b0;
    e_x = 0; e_pt = 0; last_fs = 0; fs_per = 0; n_fs = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (o_pt !== 1'b1) e_pt++;
      if (o_x !== 10'((k - 1) % 32) || o_y !== 10'(((k - 1) / 32) % 20)) e_x++;
      if (o_fs === 1'b1) begin
        if (last_fs > 0) fs_per = k - last_fs;
        last_fs = k;
        n_fs++;
      end
    end
    chk("o_ptick_high", e_pt, 0);
    chk("o_pos_track", e_x, 0);
    chk("o_frame_count", n_fs, 2);
    chk("o_frame_period", fs_per, 640);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISP, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_DISP, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter TICK_DIV, default 2, clk cycles per pixel (legal range 1..16).
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port hsync  output  1  horizontal sync, active low.
REQ-009 SHALL have port vsync  output  1  vertical sync, active low.
REQ-010 SHALL have port visible  output  1  high while the current (pixel_x, pixel_y) is in the display area.
REQ-011 SHALL have port p_tick  output  1  one-clk strobe marking a pixel advance.
REQ-012 SHALL have port pixel_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-013 SHALL have port pixel_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-014 SHALL have port line_start  output  1  one-clk pulse when pixel_x wraps to 0.
REQ-015 SHALL have port frame_start  output  1  one-clk pulse when (pixel_x, pixel_y) wraps to (0,0).

Function
REQ-016 SHALL define H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
REQ-017 SHALL assert p_tick for exactly one clk cycle every TICK_DIV cycles; the first assertion is TICK_DIV-1 cycles after reset deasserts; TICK_DIV=1 holds p_tick high.
REQ-018 SHALL advance pixel_x by 1 on the clk edge where p_tick is high; at H_TOTAL-1 it wraps to 0.
REQ-019 SHALL advance pixel_y by 1 only on a pixel_x wrap; at V_TOTAL-1 it wraps to 0 together with pixel_x.
REQ-020 SHALL hold pixel_x/pixel_y stable between p_tick edges (TICK_DIV clk cycles per pixel).
REQ-021 SHALL register hsync, vsync and visible so they describe the same pixel as pixel_x/pixel_y in every cycle (zero relative skew).
REQ-022 SHALL drive hsync low iff H_DISP+H_FP <= pixel_x < H_DISP+H_FP+H_SYNC (656..751 default).
REQ-023 SHALL drive vsync low iff V_DISP+V_FP <= pixel_y < V_DISP+V_FP+V_SYNC (490..491 default).
REQ-024 SHALL drive visible high iff pixel_x < H_DISP and pixel_y < V_DISP.
REQ-025 SHALL pulse line_start in the first cycle pixel_x equals 0 after a wrap; frame_start additionally when pixel_y also equals 0; both pulse together at frame wrap.
REQ-026 SHALL NOT pulse line_start or frame_start as a result of reset alone.
REQ-027 SHALL perform all counter comparisons at 10-bit width; parameters whose totals exceed 1023 are illegal.

Reset
REQ-028 SHALL, while reset is high at a clk edge, load pixel_x=0, pixel_y=0, tick divider=0, p_tick=0, hsync=1, vsync=1, visible=1, line_start=0, frame_start=0.
REQ-029 SHALL, on reset asserted mid-line or mid-frame, abandon the current position and restart per REQ-028 on the next edge with no extra pulses.

Structure
REQ-030 SHALL take the 640x480@60 default timing constants and H_TOTAL/V_TOTAL from shared package vga_pkg, reused by the display and address-generation blocks.
REQ-031 SHALL implement the divider as one sub-module, pixel_tick_gen (parameter TICK_DIV; ports clk, reset, p_tick).

Verification
REQ-032 SHALL cover: TICK_DIV=2, release reset -> first p_tick at cycle 1, then every 2 cycles; pixel_x=1 after the first p_tick edge.
REQ-033 SHALL cover: run one full line -> hsync low for exactly 96 pixels starting at pixel_x=656; pixel_y increments to 1 with line_start pulsing once when pixel_x returns to 0.
REQ-034 SHALL cover: run one full frame -> 800*525*2=840000 clk cycles between frame_start pulses; vsync low for lines 490..491 only.
REQ-035 SHALL cover: sample visible -> high at (639,479), low at (640,0) and (0,480); high again at (0,0).
REQ-036 SHALL cover: assert reset at (700,300) for one cycle -> next cycle outputs equal REQ-028 values, no frame_start/line_start emitted.
REQ-037 SHALL cover: TICK_DIV=1 -> p_tick constantly high, pixel_x advances every clk, frame period 420000 cycles.
